// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle ALU for the EX stage of the CPU datapath.
//
// Single-cycle operations finish one cycle after start. These are add, sub,
// and, or, srl, sra, sll and slt, plus any unused opcode, which yields zero.
// multu (shift-add) and divu (restoring) each take one step per cycle for
// WIDTH cycles, with busy held high. All results are registered.
//
// Handshake (valid/ready):
//   start is the request. It is accepted on a rising edge only while busy=0.
//   ALUOp, A and B are captured on the same edge. While busy=1, start and the
//   operand inputs are ignored, and a request in that window is lost (it is
//   not queued). done pulses for exactly one cycle when C/HI/dz update. A new
//   start may be given in the same cycle that done is high.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   operation request
//   ALUOp  in   4-bit operation code
//   A, B   in   WIDTH-bit operands
//   C      out  main result (low product / quotient)
//   HI     out  high product / remainder, 0 for single-cycle ops
//   busy   out  multiply/divide in progress
//   done   out  one-cycle completion pulse
//   dz     out  divide-by-zero flag of the last completed op
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] HI,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);

  // Operation codes
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  // FSM states
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  // FSM state. Kept as a named register so checkers can bind to it.
  logic [0:0]       state;
  logic [SHW:0]     cnt;      // iteration steps still to run
  logic             is_div;   // latched op: 1 = divu, 0 = multu
  logic [WIDTH-1:0] opnd;     // multiplicand (multu) or divisor (divu)
  logic [WIDTH-1:0] acc;      // partial product high / partial remainder
  logic [WIDTH-1:0] qr;       // multiplier bits / dividend-quotient bits

  // ------------------------------------------------------------------
  // Single-cycle result
  // ------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_c;

  assign shamt = B[SHW-1:0];

  always_comb begin
    sc_c = '0;
    case (ALUOp)
      OP_ADD: sc_c = A + B;
      OP_SUB: sc_c = A - B;
      OP_AND: sc_c = A & B;
      OP_OR:  sc_c = A | B;
      OP_SRL: sc_c = A >> shamt;
      OP_SRA: sc_c = $unsigned($signed(A) >>> shamt);
      OP_SLL: sc_c = A << shamt;
      OP_SLT: sc_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: sc_c = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // One iteration step of the multiplier and the divider
  // ------------------------------------------------------------------
  // Multiply: add the multiplicand into the high half when the current
  // multiplier LSB is set, then shift the {acc, qr} pair right by one.
  // After WIDTH steps, {acc, qr} holds the 2*WIDTH-bit product.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  assign mul_sum = {1'b0, acc} + (qr[0] ? {1'b0, opnd} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], qr[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder, then try to
  // subtract the divisor. The remainder stays below the divisor, so the
  // shifted value fits in WIDTH+1 bits and the top bit of the difference
  // is a reliable borrow. With divisor 0 the subtraction always succeeds,
  // which gives quotient all-ones and remainder equal to the dividend.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  assign div_shift = {acc, qr[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_hi    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo    = {qr[WIDTH-2:0], div_ok};

  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign step_hi = is_div ? div_hi : mul_hi;
  assign step_lo = is_div ? div_lo : mul_lo;

  // ------------------------------------------------------------------
  // Control FSM and registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      qr     <= '0;
      C      <= '0;
      HI     <= '0;
      dz     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (ALUOp == OP_MULTU || ALUOp == OP_DIVU) begin
              is_div <= (ALUOp == OP_DIVU);
              // Multiply iterates over B's bits; divide iterates over A's.
              opnd   <= (ALUOp == OP_DIVU) ? B : A;
              qr     <= (ALUOp == OP_DIVU) ? A : B;
              acc    <= '0;
              cnt    <= CNT_INIT;
              state  <= S_RUN;
            end else begin
              C    <= sc_c;
              HI   <= '0;
              dz   <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc <= step_hi;
          qr  <= step_lo;
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            // Last step: publish directly from the step logic so the
            // result appears in the same cycle that busy drops.
            C     <= step_lo;
            HI    <= step_hi;
            dz    <= is_div && (opnd == '0);
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);

endmodule
